// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: copies N_BYTES from a system-bus page into OAM, pacing reads and
// holding each byte until the PPU opens an OAM write window.
module oam_dma_ctrl #(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int START_DELAY     = 4,
   parameter int N_BYTES         = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dma_start,
   input  logic [7:0]  dma_page,
   output logic        rd_req,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   input  logic        rd_valid,
   input  logic        oam_wr_ok,
   output logic        oam_write,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_d_wr,
   output logic        busy,
   output logic        bus_lock,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      READ,
      WRITE,
      PACE
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] page;
   logic [7:0] idx;
   logic [7:0] pace;
   logic [7:0] buffer;
   logic       done_q;

   logic [7:0] src_page;
   logic       last_byte;
   logic       wr_fire;
   logic       period_met;
   logic       start_met;
   state_t     launch_state;

   // Echo RAM at E0xx-FFxx mirrors C0xx-DFxx, so fold the page before latching it.
   assign src_page     = (dma_page >= 8'hE0) ? dma_page - 8'h20 : dma_page;
   assign last_byte    = (idx == 8'(N_BYTES - 1));
   assign wr_fire      = (state == WRITE) && oam_wr_ok;
   assign period_met   = ({1'b0, pace} + 9'd1) >= 9'(CYCLES_PER_BYTE);
   assign start_met    = pace >= 8'(START_DELAY - 2);
   assign launch_state = (START_DELAY == 1) ? READ : START;

   always_comb begin
      state_next = state;
      rd_req     = 1'b0;
      rd_addr    = '0;
      oam_write  = 1'b0;
      oam_addr   = '0;
      oam_d_wr   = '0;
      case (state)
         IDLE: begin
            if (dma_start) state_next = launch_state;
         end
         START: begin
            if (start_met) state_next = READ;
         end
         READ: begin
            rd_req  = 1'b1;
            rd_addr = {page, idx};
            if (rd_valid) state_next = WRITE;
         end
         WRITE: begin
            oam_write = oam_wr_ok;
            oam_addr  = idx;
            oam_d_wr  = buffer;
            if (oam_wr_ok) begin
               if (last_byte)       state_next = IDLE;
               else if (period_met) state_next = READ;
               else                 state_next = PACE;
            end
         end
         PACE: begin
            if (period_met) state_next = READ;
         end
         default: state_next = IDLE;
      endcase
      // A new DMA register write abandons whatever is in flight.
      if (dma_start) state_next = launch_state;
   end

   assign busy     = (state != IDLE);
   assign bus_lock = busy;
   assign done     = done_q;

   // pace measures clocks since the current byte's READ entry; it also times START.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         page   <= '0;
         idx    <= '0;
         pace   <= '0;
         buffer <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         done_q <= wr_fire && last_byte && !dma_start;
         if ((state == READ) && rd_valid) buffer <= rd_data;
         if (dma_start) begin
            page <= src_page;
            idx  <= '0;
            pace <= '0;
         end else begin
            if (wr_fire && !last_byte) idx <= idx + 8'd1;
            if ((state_next == READ) && (state != READ)) pace <= '0;
            else if (pace != 8'hFF)                     pace <= pace + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: a bus/PPU responder plus a per-byte schedule model that predicts
// every read window, OAM write and done pulse from the transfer timing rules.
module tb_oam_dma_ctrl;

   localparam int CPB   = 4;
   localparam int SDLY  = 4;
   localparam int NB    = 160;
   localparam int OKLEN = 32768;

   logic        clk = 1'b0;
   logic        rst;
   logic        dma_start;
   logic [7:0]  dma_page;
   logic        rd_req;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        oam_wr_ok;
   logic        oam_write;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_d_wr;
   logic        busy;
   logic        bus_lock;
   logic        done;

   oam_dma_ctrl #(
      .CYCLES_PER_BYTE(CPB),
      .START_DELAY    (SDLY),
      .N_BYTES        (NB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .dma_start(dma_start),
      .dma_page (dma_page),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .oam_wr_ok(oam_wr_ok),
      .oam_write(oam_write),
      .oam_addr (oam_addr),
      .oam_d_wr (oam_d_wr),
      .busy     (busy),
      .bus_lock (bus_lock),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          rcyc;
      int          vcyc;
      int          wcyc;
      logic [15:0] src;
      logic [7:0]  data;
   } wr_exp_t;

   typedef struct {
      logic [7:0]  page;
      int          lat;
      logic [15:0] first_src;
      int          first_wr;
      int          done_off;
   } vec_t;

   wr_exp_t     exp_q[$];
   int          exp_done_q[$];
   int          cyc = 0;
   int          wcnt = 0;
   bit          okpat[OKLEN];
   int          lat[256];
   logic [7:0]  oam_mem[256];
   bit          oam_seen[256];
   int          done_pulses;
   int          obs_first_wr;
   int          obs_done;
   logic [15:0] obs_first_rd;
   bit          seen_rd;
   int          checks_total = 0;
   int          checks_passed = 0;

   function automatic logic [7:0] memfn(input logic [15:0] a);
      return a[15:8] ^ (a[7:0] * 8'd37) ^ 8'h5A;
   endfunction

   function automatic logic [7:0] pageMirror(input logic [7:0] p);
      return (p >= 8'hE0) ? p - 8'h20 : p;
   endfunction

   // System bus answers after lat[byte] wait clocks; PPU window follows okpat per cycle.
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) wcnt <= (rd_req && !rd_valid) ? wcnt + 1 : 0;
   assign rd_valid  = rd_req && (wcnt >= lat[rd_addr[7:0]]);
   assign rd_data   = rd_req ? memfn(rd_addr) : 8'h00;
   assign oam_wr_ok = (cyc < OKLEN) ? okpat[cyc] : 1'b1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks_total++;
      if (act === expv) checks_passed++;
      else $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, expv, cyc);
   endtask

   // Byte i reads from R, data arrives after lat[i], the write lands on the first open
   // PPU window after that, and the next read waits for both the byte period and the write.
   task automatic buildSchedule(input int s, input logic [7:0] p, input int cut);
      logic [7:0] pm;
      int r;
      int w;
      pm = pageMirror(p);
      r  = s + SDLY;
      w  = r;
      for (int i = 0; i < NB; i++) begin
         wr_exp_t x;
         w = r + lat[i] + 1;
         while (w < OKLEN - 1 && !okpat[w]) w++;
         x.rcyc = r;
         x.vcyc = r + lat[i];
         x.wcyc = w;
         x.src  = {pm, 8'(i)};
         x.data = memfn(x.src);
         if (cut < 0 || w <= cut) exp_q.push_back(x);
         r = (r + CPB > w + 1) ? r + CPB : w + 1;
      end
      if (cut < 0) exp_done_q.push_back(w + 1);
   endtask

   task automatic truncateAt(input int x);
      while (exp_q.size() > 0 && exp_q[$].wcyc > x) void'(exp_q.pop_back());
      exp_done_q.delete();
   endtask

   always @(negedge clk) begin
      wr_exp_t x;
      if (exp_q.size() > 0) begin
         if (cyc >= exp_q[0].rcyc) begin
            checkOutput("rd_req", 32'(rd_req), 32'(cyc <= exp_q[0].vcyc));
            if (cyc <= exp_q[0].vcyc) checkOutput("rd_addr", 32'(rd_addr), 32'(exp_q[0].src));
         end
      end else begin
         checkOutput("rd_req_idle", 32'(rd_req), 0);
      end
      if (rd_req && !seen_rd) begin
         seen_rd      = 1'b1;
         obs_first_rd = rd_addr;
      end
      if (oam_write) begin
         oam_mem[oam_addr]  = oam_d_wr;
         oam_seen[oam_addr] = 1'b1;
         if (obs_first_wr < 0) obs_first_wr = cyc;
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_write", 32'(oam_write), 0);
         end else begin
            x = exp_q.pop_front();
            checkOutput("wr_cycle", cyc, x.wcyc);
            checkOutput("wr_addr", 32'(oam_addr), 32'(x.src[7:0]));
            checkOutput("wr_data", 32'(oam_d_wr), 32'(x.data));
         end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].wcyc) begin
         checkOutput("missed_write", cyc, exp_q[0].wcyc);
         void'(exp_q.pop_front());
      end
      if (done) begin
         done_pulses++;
         if (obs_done < 0) obs_done = cyc;
         if (exp_done_q.size() == 0) begin
            checkOutput("unexpected_done", 32'(done), 0);
         end else begin
            checkOutput("done_cycle", cyc, exp_done_q.pop_front());
            checkOutput("busy_at_done", {30'd0, busy, bus_lock}, 0);
         end
      end
      if (exp_done_q.size() > 0 && cyc > exp_done_q[0]) begin
         checkOutput("missed_done", cyc, exp_done_q[0]);
         void'(exp_done_q.pop_front());
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitUntil(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic clearObs();
      for (int i = 0; i < 256; i++) begin
         oam_seen[i] = 1'b0;
         oam_mem[i]  = 8'h00;
      end
      done_pulses  = 0;
      obs_first_wr = -1;
      obs_done     = -1;
      obs_first_rd = 16'hFFFF;
      seen_rd      = 1'b0;
   endtask

   // Pulses dma_start in the current cycle after queueing the model's prediction.
   task automatic applyStimulus(input logic [7:0] page, output int s);
      s = cyc;
      buildSchedule(s, page, -1);
      dma_start = 1'b1;
      dma_page  = page;
      @(negedge clk);
      dma_start = 1'b0;
      dma_page  = $urandom_range(0, 255);
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || exp_done_q.size() > 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         checkOutput("drain_timeout", 32'(exp_q.size() + exp_done_q.size()), 0);
         exp_q.delete();
         exp_done_q.delete();
      end
      waitCycles(3);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_rd_req"}, 32'(rd_req), 0);
      checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 0);
      checkOutput({tag, "_oam_write"}, 32'(oam_write), 0);
      checkOutput({tag, "_oam_addr"}, 32'(oam_addr), 0);
      checkOutput({tag, "_oam_d_wr"}, 32'(oam_d_wr), 0);
      checkOutput({tag, "_busy"}, 32'(busy), 0);
      checkOutput({tag, "_bus_lock"}, 32'(bus_lock), 0);
      checkOutput({tag, "_done"}, 32'(done), 0);
   endtask

   initial begin
      vec_t vecs[6];
      int   s;
      int   s2;
      logic [7:0] pg;

      vecs[0] = '{8'hC1, 0, 16'hC100, 5, 642};
      vecs[1] = '{8'hFE, 0, 16'hDE00, 5, 642};
      vecs[2] = '{8'hDF, 1, 16'hDF00, 6, 643};
      vecs[3] = '{8'hE0, 3, 16'hC000, 8, 804};
      vecs[4] = '{8'hFF, 2, 16'hDF00, 7, 644};
      vecs[5] = '{8'h00, 0, 16'h0000, 5, 642};

      for (int i = 0; i < OKLEN; i++) okpat[i] = 1'b1;
      for (int i = 0; i < 256; i++) lat[i] = 0;
      clearObs();
      rst       = 1'b0;
      dma_start = 1'b0;
      dma_page  = 8'h00;
      waitCycles(2);
      checkAllZero("reset");

      // dma_start while reset is held must be ignored.
      dma_start = 1'b1;
      dma_page  = 8'hC1;
      @(negedge clk);
      dma_start = 1'b0;
      checkOutput("reset_wins_busy", 32'(busy), 0);
      rst = 1'b1;
      waitCycles(3);
      checkOutput("reset_wins_idle", 32'(busy), 0);

      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 256; i++) lat[i] = vecs[v].lat;
         clearObs();
         applyStimulus(vecs[v].page, s);
         checkOutput("busy_after_start", 32'(busy), 1);
         checkOutput("bus_lock_after_start", 32'(bus_lock), 1);
         waitIdle(2000);
         checkOutput("first_rd_addr", 32'(obs_first_rd), 32'(vecs[v].first_src));
         checkOutput("first_wr_offset", obs_first_wr - s, vecs[v].first_wr);
         checkOutput("done_offset", obs_done - s, vecs[v].done_off);
         checkOutput("done_count", done_pulses, 1);
         checkOutput("oam_last_byte", 32'(oam_mem[159]), 32'(memfn({vecs[v].first_src[15:8], 8'd159})));
      end
      for (int i = 0; i < 256; i++) lat[i] = 0;

      // PPU closes the window for 50 clocks just as byte 10 becomes writable.
      clearObs();
      s = cyc;
      for (int c = s + 45; c < s + 95; c++) okpat[c] = 1'b0;
      applyStimulus(8'h42, s);
      waitUntil(s + 70);
      checkOutput("stall_no_write", 32'(oam_write), 0);
      checkOutput("stall_addr_held", 32'(oam_addr), 10);
      checkOutput("stall_data_held", 32'(oam_d_wr), 32'(memfn(16'h420A)));
      waitUntil(s + 95);
      checkOutput("stall_release_write", 32'(oam_write), 1);
      waitUntil(s + 96);
      checkOutput("stall_next_read", 32'(rd_req), 1);
      checkOutput("stall_next_addr", 32'(rd_addr), 32'(16'h420B));
      waitIdle(2000);
      for (int c = s + 45; c < s + 95; c++) okpat[c] = 1'b1;

      // Restart with a new page while byte 37 is being read.
      clearObs();
      applyStimulus(8'hC1, s);
      waitUntil(s + 152);
      truncateAt(cyc);
      applyStimulus(8'h80, s2);
      checkOutput("restart_req_drop", 32'(rd_req), 0);
      checkOutput("restart_busy", 32'(busy), 1);
      waitUntil(s2 + 3);
      checkOutput("restart_old_byte36", 32'(oam_mem[36]), 32'(memfn(16'hC124)));
      checkOutput("restart_byte37_unwritten", 32'(oam_seen[37]), 0);
      waitUntil(s2 + 4);
      checkOutput("restart_first_addr", 32'(rd_addr), 32'(16'h8000));
      waitIdle(2000);
      checkOutput("restart_done_count", done_pulses, 1);
      checkOutput("restart_new_byte36", 32'(oam_mem[36]), 32'(memfn(16'h8024)));

      // Restart landing on the final write: that write happens, its done does not.
      clearObs();
      applyStimulus(8'h33, s);
      waitUntil(s + 641);
      truncateAt(cyc);
      applyStimulus(8'h34, s2);
      checkOutput("final_restart_byte159", 32'(oam_seen[159]), 1);
      waitIdle(2000);
      checkOutput("final_restart_done_count", done_pulses, 1);
      checkOutput("final_restart_last", 32'(oam_mem[159]), 32'(memfn(16'h349F)));

      // Reset during the clock byte 90 is written.
      clearObs();
      applyStimulus(8'h5A, s);
      waitUntil(s + 365);
      rst = 1'b0;
      truncateAt(cyc);
      @(negedge clk);
      rst = 1'b1;
      checkAllZero("midreset");
      waitCycles(30);
      checkOutput("midreset_idle_busy", 32'(busy), 0);
      checkOutput("midreset_no_done", done_pulses, 0);
      checkOutput("midreset_byte90", 32'(oam_seen[90]), 1);
      checkOutput("midreset_byte91", 32'(oam_seen[91]), 0);

      // Random bus latencies and PPU windows against the schedule model.
      for (int k = 0; k < 3; k++) begin
         clearObs();
         pg = 8'($urandom_range(0, 255));
         for (int i = 0; i < 256; i++) lat[i] = $urandom_range(0, 3);
         s = cyc;
         for (int c = s; c < s + 2500; c++) okpat[c] = ($urandom_range(0, 3) != 0);
         applyStimulus(pg, s);
         waitIdle(4000);
         checkOutput("rand_done_count", done_pulses, 1);
         checkOutput("rand_first_rd", 32'(obs_first_rd), 32'({pageMirror(pg), 8'h00}));
         for (int c = s; c < s + 2500; c++) okpat[c] = 1'b1;
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
